mdio_phy_slave: RTL
===================

Name: mdio_phy_slave

Overview:
- PHY-side MDIO management slave.
- Sits directly downstream of the MDIO master controller. Consumes its mdc, mdio_out and mdio_oe, and returns read data on mdio_in.
- Decodes 32-bit Clause-22 frames, MSB first:
  - ST[31:30]=01
  - OP[29:28]: 01 = write, 10 = read
  - PHYAD[27:23]
  - REGAD[22:18]
  - TA[17:16]
  - DATA[15:0]
- Holds a 32x16 management register bank.

Parameters:
- PHY_ADDR, 5'h0A, PHY address this slave responds to.
- ID_HI, 16'h0141, reset and constant value of register 2 (read-only).
- ID_LO, 16'h0CC2, reset and constant value of register 3 (read-only).

Ports:
- clk  input  1  system clock; mdc is generated in this domain.
- reset  input  1  synchronous, active-high reset.
- mdc  input  1  management clock from the master controller.
- mdio_out  input  1  serial data from the master.
- mdio_oe  input  1  master output enable; mdio_out is valid only when 1.
- mdio_in  output  1  serial read data back to the master.
- mdio_in_en  output  1  slave drive enable for mdio_in.
- wr_strobe  output  1  one-clk pulse when a register write commits.
- wr_addr  output  5  register address of the last committed write.
- wr_data  output  16  data of the last committed write.
- rd_strobe  output  1  one-clk pulse when a read frame completes.
- frame_err  output  1  one-clk pulse on an aborted or rejected frame.

Behaviour:
- Single clock; reset is synchronous and active-high. All state is updated on posedge clk only.
- mdc edge detection:
  - mdc_q is mdc registered in clk.
  - rise = mdc & ~mdc_q; fall = ~mdc & mdc_q.
  - All frame logic advances only on rise/fall qualified cycles.
- Reset values:
  - Outputs: mdio_in=0, mdio_in_en=0, wr_strobe=0, wr_addr=0, wr_data=0, rd_strobe=0, frame_err=0.
  - FSM in IDLE, bit counter 0.
  - Registers: reg2=ID_HI, reg3=ID_LO, all others 16'h0000.
- Sampling rule: mdio_out is sampled on rise only when mdio_oe=1.
- FSM states: IDLE, HEADER, WR_TA, WR_DATA, RD_TA, RD_DATA, DISCARD.
- IDLE:
  - Shifts sampled bits into a 2-bit history.
  - When the history equals 01 (preamble ones are tolerated), go to HEADER with bit count=2.
- HEADER:
  - Collects OP, PHYAD, REGAD until count=14.
  - At count=14:
    - PHYAD==PHY_ADDR and OP=01 -> WR_TA.
    - PHYAD==PHY_ADDR and OP=10 -> RD_TA; latch reg[REGAD] into the read shift register.
    - Otherwise -> DISCARD and pulse frame_err.
- WR_TA:
  - Two rises; TA bit values are ignored.
  - Then WR_DATA.
- WR_DATA:
  - Shifts 16 bits.
  - On the rise of bit 32, commit the write, unless REGAD is 2 or 3 (read-only: no write, no wr_strobe).
  - On commit, wr_strobe pulses exactly 1 clk in the cycle after that rise, with wr_addr/wr_data updated in the same cycle.
  - Then return to IDLE.
- RD_TA:
  - The master must release (mdio_oe=0) for the first TA bit. If mdio_oe=1 on that rise -> DISCARD and pulse frame_err.
  - On the fall following the first TA rise: assert mdio_in_en=1 and drive mdio_in=0 (second TA bit).
- RD_DATA:
  - On each subsequent fall, drive the next read bit, MSB first, for 16 bits.
  - On the fall after bit 0 has been sampled (bit 32 rise), deassert mdio_in_en, force mdio_in=0, pulse rd_strobe 1 clk, and return to IDLE.
- DISCARD:
  - Counts rises, regardless of mdio_oe, to bit 32 with no outputs driven, then returns to IDLE.
- Abort:
  - If mdio_oe falls while in HEADER, WR_TA or WR_DATA before bit 32: frame_err pulse, no write, return to IDLE.
- No timeout: a stopped mdc holds the current state indefinitely.
- Simultaneous events:
  - Reset has priority over everything, including an in-progress commit. Reset mid-read releases mdio_in_en in the same cycle reset is sampled.
- mdio_in_en is never 1 while the FSM is outside RD_TA/RD_DATA.

Test Plan:
- Reset then idle: hold reset 2 clk -> all outputs 0, read of reg2 later returns 16'h0141.
- Write frame 32'h5556ABCD (PHY 0x0A, REG 0x15, data ABCD) with PHY_ADDR=5'h0A -> one wr_strobe pulse, wr_addr=5'h15, wr_data=16'hABCD.
- Read frame 32'h6556xxxx after the write, master releases after 14 bits -> mdio_in_en rises after the first TA bit; the master captures 0 then 1010_1011_1100_1101; one rd_strobe pulse, then en=0.
- Write to reg 3 (frame 32'h550EFFFF) -> no wr_strobe, no frame_err; a subsequent read of reg 3 returns 16'h0CC2.
- Frame with PHYAD 5'h01 (32'h5096_1234) -> frame_err pulse at bit 14, no wr_strobe, mdio_in_en stays 0 through bit 32, next valid frame is accepted.
- Abort and reset: mdio_oe dropped after 20 bits of a write -> frame_err pulse, register unchanged. Reset asserted mid read-data -> mdio_in_en=0 in the reset cycle, FSM returns to IDLE.

Source files
------------

// File: rtl/mdio_phy_slave.sv
// PHY-side Clause-22 MDIO slave: decodes master frames sampled on mdc edges
// and serves a 32x16 management register bank with read-only ID registers.
`timescale 1ns/1ps
module mdio_phy_slave #(
  parameter logic [4:0]  PHY_ADDR = 5'h0A,
  parameter logic [15:0] ID_HI    = 16'h0141,
  parameter logic [15:0] ID_LO    = 16'h0CC2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_out,
  input  logic        mdio_oe,
  output logic        mdio_in,
  output logic        mdio_in_en,
  output logic        wr_strobe,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        rd_strobe,
  output logic        frame_err
);

  typedef enum logic [2:0] {IDLE, HEADER, WR_TA, WR_DATA, RD_TA, RD_DATA, DISCARD} state_t;

  state_t      state_reg, state_next;
  logic        mdc_q;
  logic        rise, fall, sample;
  logic [5:0]  cnt_reg, cnt_next;
  logic [1:0]  hist_reg, hist_next;
  logic [10:0] hdr_reg, hdr_next;
  logic [11:0] hdr_full;
  logic [15:0] shift_reg, shift_next;
  logic [15:0] regs [32];
  logic [15:0] rd_value;
  logic        commit, reject, abort, rd_done, drive_ta, drive_bit;

  logic        en_reg, en_next, in_reg, in_next;
  logic        wr_strobe_reg, wr_strobe_next, rd_strobe_reg, rd_strobe_next;
  logic        frame_err_reg, frame_err_next;
  logic [4:0]  wr_addr_reg, wr_addr_next;
  logic [15:0] wr_data_reg, wr_data_next;

  assign rise     = mdc & ~mdc_q;
  assign fall     = ~mdc & mdc_q;
  assign sample   = rise & mdio_oe;
  assign hdr_full = {hdr_reg, mdio_out};
  assign rd_value = regs[hdr_full[4:0]];

  always_ff @(posedge clk) begin
    mdc_q <= mdc;
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      hist_reg      <= 2'b11;
      hdr_reg       <= '0;
      shift_reg     <= '0;
      en_reg        <= 1'b0;
      in_reg        <= 1'b0;
      wr_strobe_reg <= 1'b0;
      rd_strobe_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      hist_reg      <= hist_next;
      hdr_reg       <= hdr_next;
      shift_reg     <= shift_next;
      en_reg        <= en_next;
      in_reg        <= in_next;
      wr_strobe_reg <= wr_strobe_next;
      rd_strobe_reg <= rd_strobe_next;
      frame_err_reg <= frame_err_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
    end
  end

  // Registers 2 and 3 are never written, so their reset value stays constant.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= (i == 2) ? ID_HI : (i == 3) ? ID_LO : 16'h0000;
    end else if (commit) begin
      regs[hdr_reg[4:0]] <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hist_next  = hist_reg;
    hdr_next   = hdr_reg;
    shift_next = shift_reg;
    commit     = 1'b0;
    reject     = 1'b0;
    abort      = 1'b0;
    rd_done    = 1'b0;
    drive_ta   = 1'b0;
    drive_bit  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sample) begin
          hist_next = {hist_reg[0], mdio_out};
          if ({hist_reg[0], mdio_out} == 2'b01) begin
            state_next = HEADER;
            cnt_next   = 6'd2;
            hist_next  = 2'b11;
          end
        end
      end
      HEADER: begin
        if (rise && !mdio_oe) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (rise) begin
          hdr_next = hdr_full[10:0];
          cnt_next = cnt_reg + 6'd1;
          if (cnt_reg == 6'd13) begin
            if (hdr_full[9:5] == PHY_ADDR && hdr_full[11:10] == 2'b01) begin
              state_next = WR_TA;
            end else if (hdr_full[9:5] == PHY_ADDR && hdr_full[11:10] == 2'b10) begin
              state_next = RD_TA;
              shift_next = rd_value;
            end else begin
              state_next = DISCARD;
              reject     = 1'b1;
            end
          end
        end
      end
      WR_TA: begin
        if (rise && !mdio_oe) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (rise) begin
          cnt_next = cnt_reg + 6'd1;
          if (cnt_reg == 6'd15)
            state_next = WR_DATA;
        end
      end
      WR_DATA: begin
        if (rise && !mdio_oe) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (rise) begin
          shift_next = {shift_reg[14:0], mdio_out};
          cnt_next   = cnt_reg + 6'd1;
          if (cnt_reg == 6'd31) begin
            state_next = IDLE;
            commit     = (hdr_reg[4:0] != 5'd2) && (hdr_reg[4:0] != 5'd3);
          end
        end
      end
      RD_TA: begin
        if (rise) begin
          cnt_next = cnt_reg + 6'd1;
          if (cnt_reg == 6'd14 && mdio_oe) begin
            state_next = DISCARD;
            reject     = 1'b1;
          end
        end else if (fall && cnt_reg == 6'd15) begin
          drive_ta = 1'b1;
        end else if (fall && cnt_reg == 6'd16) begin
          drive_bit  = 1'b1;
          shift_next = {shift_reg[14:0], 1'b0};
          state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rise) begin
          cnt_next = cnt_reg + 6'd1;
        end else if (fall && cnt_reg == 6'd32) begin
          rd_done    = 1'b1;
          state_next = IDLE;
        end else if (fall) begin
          drive_bit  = 1'b1;
          shift_next = {shift_reg[14:0], 1'b0};
        end
      end
      DISCARD: begin
        if (rise) begin
          cnt_next = cnt_reg + 6'd1;
          if (cnt_reg == 6'd31)
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    en_next        = en_reg;
    in_next        = in_reg;
    wr_strobe_next = commit;
    rd_strobe_next = rd_done;
    frame_err_next = reject | abort;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    if (commit) begin
      wr_addr_next = hdr_reg[4:0];
      wr_data_next = shift_next;
    end
    if (drive_ta) begin
      en_next = 1'b1;
      in_next = 1'b0;
    end
    if (drive_bit) begin
      en_next = 1'b1;
      in_next = shift_reg[15];
    end
    // The slave only ever drives the line during a read turnaround/data phase.
    if (state_next != RD_TA && state_next != RD_DATA) begin
      en_next = 1'b0;
      in_next = 1'b0;
    end
  end

  // Reset releases the line combinationally so a mid-read reset frees it at once.
  assign mdio_in_en = en_reg & ~reset;
  assign mdio_in    = in_reg & ~reset;
  assign wr_strobe  = wr_strobe_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign rd_strobe  = rd_strobe_reg;
  assign frame_err  = frame_err_reg;

endmodule
